// File: rtl/simple_reg_writer.sv
// Writable register file with an in-order write-back queue; both read ports
// forward the youngest queued write to the same address ahead of the array.
module simple_reg_writer #(
  parameter int addr_width_p  = 4,
  parameter int queue_depth_p = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_valid_i,
  input  logic [addr_width_p-1:0]          wr_addr_i,
  input  logic [31:0]                      wr_data_i,
  output logic                             wr_ready_o,
  input  logic                             commit_en_i,
  input  logic [addr_width_p-1:0]          rs_addr_i,
  input  logic [addr_width_p-1:0]          rd_addr_i,
  output logic [31:0]                      rs_val_o,
  output logic [31:0]                      rd_val_o,
  output logic [$clog2(queue_depth_p):0]   count_o,
  output logic                             busy_o
);

  localparam int num_regs_lp = 1 << addr_width_p;
  localparam int ptr_w_lp    = $clog2(queue_depth_p);
  localparam int cnt_w_lp    = ptr_w_lp + 1;

  logic [31:0]             rf     [num_regs_lp];
  logic [addr_width_p-1:0] q_addr [queue_depth_p];
  logic [31:0]             q_data [queue_depth_p];
  logic [ptr_w_lp-1:0]     head;
  logic [ptr_w_lp-1:0]     tail;
  logic [cnt_w_lp-1:0]     count;
  logic                    push;
  logic                    pop;

  // Ready looks only at the registered count, so a same-cycle commit never frees a slot early.
  assign wr_ready_o = (count < cnt_w_lp'(queue_depth_p));
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = commit_en_i & (count != '0);
  assign count_o    = count;
  assign busy_o     = (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < num_regs_lp; i++) begin
        rf[i] <= 32'(i);
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        rf[q_addr[head]] <= q_data[head];
        head             <= head + ptr_w_lp'(1);
      end
      if (push) begin
        tail <= tail + ptr_w_lp'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + cnt_w_lp'(1);
        2'b01:   count <= count - cnt_w_lp'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload needs no reset: entries are only ever read below count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= wr_addr_i;
      q_data[tail] <= wr_data_i;
    end
  end

  // Walk queued entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [ptr_w_lp-1:0] idx;
    idx      = '0;
    rs_val_o = rf[rs_addr_i];
    rd_val_o = rf[rd_addr_i];
    for (int k = 0; k < queue_depth_p; k++) begin
      idx = head + ptr_w_lp'(k);
      if (cnt_w_lp'(k) < count) begin
        if (q_addr[idx] == rs_addr_i) rs_val_o = q_data[idx];
        if (q_addr[idx] == rd_addr_i) rd_val_o = q_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_simple_reg_writer.sv
// Bench for simple_reg_writer: directed scenarios plus random traffic, checked
// every cycle against a queue-and-array model of the register writer.
module tb_simple_reg_writer;

  localparam int AW = 4;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          wr_ready;
  logic          commit_en = 1'b0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rs_val;
  logic [31:0]   rd_val;
  logic [2:0]    count;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  simple_reg_writer #(.addr_width_p(AW), .queue_depth_p(QD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid_i  (wr_valid),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .commit_en_i (commit_en),
    .rs_addr_i   (rs_addr),
    .rd_addr_i   (rd_addr),
    .rs_val_o    (rs_val),
    .rd_val_o    (rd_val),
    .count_o     (count),
    .busy_o      (busy)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mrf[16];

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    logic [31:0] v;
    v = mrf[a];
    foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      for (int i = 0; i < 16; i++) mrf[i] = 32'(i);
    end else begin
      bit   acc;
      bit   com;
      ent_t e;
      acc = wr_valid && (mq.size() < QD);
      com = commit_en && (mq.size() != 0);
      if (com) begin
        e = mq.pop_front();
        mrf[e.a] = e.d;
      end
      if (acc) mq.push_back(ent_t'{wr_addr, wr_data});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", 32'(count), 32'(mq.size()));
      check("model_busy", 32'(busy), 32'(mq.size() != 0));
      check("model_ready", 32'(wr_ready), 32'(mq.size() < QD));
      check("model_rs_val", rs_val, model_read(rs_addr));
      check("model_rd_val", rd_val, model_read(rd_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    rs_addr = 4'd5;
    rd_addr = 4'd15;
    @(negedge clk);
    check("reset_rs", rs_val, 32'd5);
    check("reset_rd", rd_val, 32'd15);
    check("reset_ready", 32'(wr_ready), 32'd1);
    check("reset_count", 32'(count), 32'd0);

    // write and forward
    tick();
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; rs_addr = 4'd3;
    @(negedge clk);
    check("presented_not_fwd", rs_val, 32'd3);
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    check("fwd_rs", rs_val, 32'hDEADBEEF);
    check("fwd_count", 32'(count), 32'd1);
    tick();
    commit_en = 1'b1;
    @(negedge clk);
    check("pre_commit_count", 32'(count), 32'd1);
    tick();
    commit_en = 1'b0;
    @(negedge clk);
    check("post_commit_count", 32'(count), 32'd0);
    check("post_commit_rs", rs_val, 32'hDEADBEEF);

    // fill and backpressure
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_valid = 1'b1; wr_addr = AW'(i + 1); wr_data = 32'hA0 + 32'(i);
    end
    tick();
    wr_addr = 4'd5; wr_data = 32'hA4;
    @(negedge clk);
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    tick();
    commit_en = 1'b1;
    @(negedge clk);
    check("held_ready", 32'(wr_ready), 32'd0);
    tick();
    commit_en = 1'b0; rd_addr = 4'd1;
    @(negedge clk);
    check("after_pop_count", 32'(count), 32'd3);
    check("after_pop_ready", 32'(wr_ready), 32'd1);
    check("rf1_committed", rd_val, 32'hA0);
    tick();
    wr_valid = 1'b0; rs_addr = 4'd5;
    @(negedge clk);
    check("fifth_accepted_count", 32'(count), 32'd4);
    check("fifth_fwd", rs_val, 32'hA4);
    tick();
    commit_en = 1'b1;
    repeat (4) tick();
    commit_en = 1'b0;
    @(negedge clk);
    check("fill_drained", 32'(count), 32'd0);
    check("fill_rf5", rs_val, 32'hA4);

    // same-address ordering
    rs_addr = 4'd7;
    tick(); wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h11;
    tick(); wr_data = 32'h22;
    tick(); wr_data = 32'h33;
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    check("same_addr_youngest", rs_val, 32'h33);
    check("same_addr_count", 32'(count), 32'd3);
    tick(); commit_en = 1'b1;
    tick();
    @(negedge clk);
    check("same_addr_mid_drain", rs_val, 32'h33);
    tick(); tick(); commit_en = 1'b0;
    @(negedge clk);
    check("same_addr_drained", 32'(count), 32'd0);
    check("same_addr_rf7", rs_val, 32'h33);

    // simultaneous push/pop with pointer wrap
    commit_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'h100 + 32'(i);
      @(negedge clk);
      if (i >= 1) check("stream_count", 32'(count), 32'd1);
    end
    tick(); wr_valid = 1'b0;
    tick();
    commit_en = 1'b0; rs_addr = 4'd0; rd_addr = 4'd9;
    @(negedge clk);
    check("stream_drained", 32'(count), 32'd0);
    check("stream_rf0", rs_val, 32'h100);
    check("stream_rf9", rd_val, 32'h109);

    // reset mid-operation
    rs_addr = 4'd2;
    for (int j = 0; j < 3; j++) begin
      tick(); wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'h200 + 32'(j);
    end
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_count", 32'(count), 32'd3);
    check("pre_reset_fwd", rs_val, 32'h202);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_ready", 32'(wr_ready), 32'd1);
    check("midreset_rs", rs_val, 32'd2);
    #3 reset_n = 1'b1;

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      commit_en = ($urandom_range(0, 2) != 0);
      rs_addr   = AW'($urandom_range(0, 15));
      rd_addr   = AW'($urandom_range(0, 15));
    end
    tick();
    wr_valid = 1'b0; commit_en = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("final_drained", 32'(count), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
